// File: rtl/ac97_cmd_sched_if.sv
// Requester-side handshake of the AC'97 command scheduler: one register
// read/write transaction at a time, accepted with a single-cycle ack.
interface ac97_cmd_sched_if;
    logic        user_req;
    logic        user_rnw;
    logic [6:0]  user_addr;
    logic [15:0] user_wdata;
    logic        user_ack;
    logic [15:0] user_rdata;
    logic        user_rdata_valid;
    logic        user_timeout;

    modport master (
        output user_req, user_rnw, user_addr, user_wdata,
        input  user_ack, user_rdata, user_rdata_valid, user_timeout
    );

    modport slave (
        input  user_req, user_rnw, user_addr, user_wdata,
        output user_ack, user_rdata, user_rdata_valid, user_timeout
    );
endinterface

// File: rtl/ac97_cmd_sched.sv
// AC-link command slot 1/2 owner: brings the codec up (reset, volumes, power
// poll), then serves one requester with one register command per frame.
module ac97_cmd_sched #(
    parameter logic [15:0] MASTER_VOL     = 16'h0000,
    parameter logic [15:0] PCM_VOL        = 16'h0808,
    parameter int unsigned TIMEOUT_FRAMES = 4,
    parameter int unsigned POLL_LIMIT     = 255
) (
    input  logic               ac97_bitclk,
    input  logic               rst,
    input  logic               ac97_strobe,
    input  logic [19:0]        ac97_in_slot1,
    input  logic               ac97_in_slot1_valid,
    input  logic [19:0]        ac97_in_slot2,
    output logic [19:0]        ac97_out_slot1,
    output logic               ac97_out_slot1_valid,
    output logic [19:0]        ac97_out_slot2,
    output logic               ac97_out_slot2_valid,
    ac97_cmd_sched_if.slave    user,
    output logic               codec_ready,
    output logic               init_error
);

    typedef enum logic [2:0] {
        S_RST, S_MVOL, S_PVOL, S_POLL, S_PWAIT, S_IDLE, S_UWAIT
    } state_t;

    localparam logic [3:0] TMO        = 4'(TIMEOUT_FRAMES);
    localparam logic [7:0] PLIM       = 8'(POLL_LIMIT);
    localparam logic [6:0] REG_RESET  = 7'h00;
    localparam logic [6:0] REG_MVOL   = 7'h02;
    localparam logic [6:0] REG_PVOL   = 7'h18;
    localparam logic [6:0] REG_PWR    = 7'h26;

    state_t      r_state;
    logic [19:0] r_slot1;
    logic        r_slot1_v;
    logic [19:0] r_slot2;
    logic        r_slot2_v;
    logic [3:0]  r_frame_cnt;
    logic [7:0]  r_poll_cnt;
    logic [6:0]  r_uaddr;
    logic        r_ack;
    logic [15:0] r_rdata;
    logic        r_rvalid;
    logic        r_tmo;
    logic        r_ready;
    logic        r_err;

    state_t      w_state_nxt;
    logic        w_load;
    logic        w_rnw;
    logic [6:0]  w_addr;
    logic [15:0] w_wdata;
    logic [3:0]  w_frame_nxt;
    logic [3:0]  w_frame_inc;
    logic [7:0]  w_poll_nxt;
    logic [7:0]  w_poll_inc;
    logic        w_ack;
    logic        w_rvalid;
    logic        w_tmo;
    logic        w_ready_set;
    logic        w_err_set;
    logic        w_fail;
    logic [6:0]  w_stat_addr;
    logic        w_unused;

    assign w_stat_addr = ac97_in_slot1[18:12];
    assign w_frame_inc = (r_frame_cnt == 4'hF) ? r_frame_cnt : r_frame_cnt + 4'd1;
    assign w_poll_inc  = (r_poll_cnt == 8'hFF) ? r_poll_cnt : r_poll_cnt + 8'd1;
    assign w_unused    = ^{ac97_in_slot1[19], ac97_in_slot1[11:0], ac97_in_slot2[3:0]};

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_rnw       = 1'b0;
        w_addr      = 7'h00;
        w_wdata     = 16'h0000;
        w_frame_nxt = r_frame_cnt;
        w_poll_nxt  = r_poll_cnt;
        w_ack       = 1'b0;
        w_rvalid    = 1'b0;
        w_tmo       = 1'b0;
        w_ready_set = 1'b0;
        w_err_set   = 1'b0;
        w_fail      = 1'b0;
        case (r_state)
            S_RST: begin
                w_load = 1'b1; w_addr = REG_RESET; w_wdata = 16'h0000;
                w_state_nxt = S_MVOL;
            end
            S_MVOL: begin
                w_load = 1'b1; w_addr = REG_MVOL; w_wdata = MASTER_VOL;
                w_state_nxt = S_PVOL;
            end
            S_PVOL: begin
                w_load = 1'b1; w_addr = REG_PVOL; w_wdata = PCM_VOL;
                w_state_nxt = S_POLL;
            end
            S_POLL: begin
                w_load = 1'b1; w_rnw = 1'b1; w_addr = REG_PWR;
                w_frame_nxt = 4'd0;
                w_state_nxt = S_PWAIT;
            end
            S_PWAIT: begin
                w_frame_nxt = w_frame_inc;
                if (ac97_in_slot1_valid && w_stat_addr == REG_PWR) begin
                    if (ac97_in_slot2[7:4] == 4'hF) begin
                        w_ready_set = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_fail = 1'b1;
                    end
                end else if (w_frame_inc >= TMO) begin
                    w_fail = 1'b1;
                end
                if (w_fail) begin
                    w_poll_nxt  = w_poll_inc;
                    w_err_set   = (w_poll_inc >= PLIM);
                    w_state_nxt = S_POLL;
                end
            end
            S_IDLE: begin
                if (user.user_req) begin
                    w_load  = 1'b1;
                    w_ack   = 1'b1;
                    w_rnw   = user.user_rnw;
                    w_addr  = user.user_addr;
                    w_wdata = user.user_wdata;
                    if (user.user_rnw) begin
                        w_frame_nxt = 4'd0;
                        w_state_nxt = S_UWAIT;
                    end
                end
            end
            S_UWAIT: begin
                w_frame_nxt = w_frame_inc;
                // A match on the final frame beats the timeout.
                if (ac97_in_slot1_valid && w_stat_addr == r_uaddr) begin
                    w_rvalid    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_frame_inc >= TMO) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_RST;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the same pre-edge values.
    always_ff @(posedge ac97_bitclk or posedge rst) begin
        if (rst) begin
            r_state <= S_RST;
        end else if (ac97_strobe) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge ac97_bitclk or posedge rst) begin
        if (rst) begin
            r_slot1     <= 20'h0;
            r_slot1_v   <= 1'b0;
            r_slot2     <= 20'h0;
            r_slot2_v   <= 1'b0;
            r_frame_cnt <= 4'd0;
            r_poll_cnt  <= 8'd0;
            r_uaddr     <= 7'h00;
            r_ack       <= 1'b0;
            r_rdata     <= 16'h0000;
            r_rvalid    <= 1'b0;
            r_tmo       <= 1'b0;
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_ack    <= 1'b0;
            r_rvalid <= 1'b0;
            r_tmo    <= 1'b0;
            if (ac97_strobe) begin
                r_frame_cnt <= w_frame_nxt;
                r_poll_cnt  <= w_poll_nxt;
                r_ack       <= w_ack;
                r_rvalid    <= w_rvalid;
                r_tmo       <= w_tmo;
                // A command occupies exactly one frame; slots clear unless reloaded.
                if (w_load) begin
                    r_slot1   <= {w_rnw, w_addr, 12'h000};
                    r_slot1_v <= 1'b1;
                    r_slot2   <= w_rnw ? 20'h0 : {w_wdata, 4'h0};
                    r_slot2_v <= ~w_rnw;
                end else begin
                    r_slot1   <= 20'h0;
                    r_slot1_v <= 1'b0;
                    r_slot2   <= 20'h0;
                    r_slot2_v <= 1'b0;
                end
                if (w_ack && w_rnw) r_uaddr <= w_addr;
                if (w_rvalid)       r_rdata <= ac97_in_slot2[19:4];
                if (w_ready_set)    r_ready <= 1'b1;
                if (w_err_set)      r_err   <= 1'b1;
            end
        end
    end

    assign ac97_out_slot1        = r_slot1;
    assign ac97_out_slot1_valid  = r_slot1_v;
    assign ac97_out_slot2        = r_slot2;
    assign ac97_out_slot2_valid  = r_slot2_v;
    assign user.user_ack         = r_ack;
    assign user.user_rdata       = r_rdata;
    assign user.user_rdata_valid = r_rvalid;
    assign user.user_timeout     = r_tmo;
    assign codec_ready           = r_ready;
    assign init_error            = r_err;

endmodule

// File: tb/tb_ac97_cmd_sched.sv
// Directed bench for ac97_cmd_sched: expected slot commands are queued as each
// frame is driven and compared once the strobe edge has produced them.
module tb_ac97_cmd_sched;

    typedef struct packed {
        logic [19:0] s1;
        logic        v1;
        logic [19:0] s2;
        logic        v2;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        strobe;
    logic [19:0] in_slot1;
    logic        in_v1;
    logic [19:0] in_slot2;
    logic [19:0] out_slot1;
    logic        out_v1;
    logic [19:0] out_slot2;
    logic        out_v2;
    logic        codec_ready;
    logic        init_error;

    ac97_cmd_sched_if u_if ();

    ac97_cmd_sched u_dut (
        .ac97_bitclk          (clk),
        .rst                  (rst),
        .ac97_strobe          (strobe),
        .ac97_in_slot1        (in_slot1),
        .ac97_in_slot1_valid  (in_v1),
        .ac97_in_slot2        (in_slot2),
        .ac97_out_slot1       (out_slot1),
        .ac97_out_slot1_valid (out_v1),
        .ac97_out_slot2       (out_slot2),
        .ac97_out_slot2_valid (out_v2),
        .user                 (u_if),
        .codec_ready          (codec_ready),
        .init_error           (init_error)
    );

    always #5 clk = ~clk;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    cmd_t exp_q[$];

    logic        obs_ack, obs_rv, obs_tmo, obs_v1;
    logic        late_ack, late_rv, late_tmo;
    logic [19:0] obs_s1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic cmd_t cmd_wr(input logic [6:0] a, input logic [15:0] d);
        cmd_t c;
        c.s1 = {1'b0, a, 12'h000}; c.v1 = 1'b1; c.s2 = {d, 4'h0}; c.v2 = 1'b1;
        return c;
    endfunction

    function automatic cmd_t cmd_rd(input logic [6:0] a);
        cmd_t c;
        c.s1 = {1'b1, a, 12'h000}; c.v1 = 1'b1; c.s2 = 20'h0; c.v2 = 1'b0;
        return c;
    endfunction

    function automatic cmd_t cmd_none();
        cmd_t c;
        c = '0;
        return c;
    endfunction

    // One AC-link frame: strobe with the given status slots, then three quiet cycles.
    task automatic frame(input logic [19:0] s1, input logic v1, input logic [19:0] s2);
        cmd_t e;
        in_slot1 = s1; in_v1 = v1; in_slot2 = s2; strobe = 1'b1;
        @(posedge clk); #1;
        strobe = 1'b0; in_slot1 = 20'h0; in_v1 = 1'b0; in_slot2 = 20'h0;
        obs_ack = u_if.user_ack; obs_rv = u_if.user_rdata_valid; obs_tmo = u_if.user_timeout;
        obs_s1 = out_slot1; obs_v1 = out_v1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("slot1", 32'({out_v1, out_slot1}), 32'({e.v1, e.s1}));
            check("slot2", 32'({out_v2, out_slot2}), 32'({e.v2, e.s2}));
        end
        @(posedge clk); #1;
        late_ack = u_if.user_ack; late_rv = u_if.user_rdata_valid; late_tmo = u_if.user_timeout;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic req, input logic rnw, input logic [6:0] a, input logic [15:0] d);
        u_if.user_req = req; u_if.user_rnw = rnw; u_if.user_addr = a; u_if.user_wdata = d;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int polls, last_poll, since, max_gap, min_gap, acks, err_frame, polls_at_err, ready_seen;
        rst = 1'b1; strobe = 1'b0; in_slot1 = 20'h0; in_v1 = 1'b0; in_slot2 = 20'h0;
        set_req(1'b0, 1'b0, 7'h00, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        check("rst_slots", 32'({out_v1, out_v2, out_slot1 | out_slot2}), 32'h0);
        check("rst_flags", 32'({codec_ready, init_error, u_if.user_ack, u_if.user_rdata_valid,
                                u_if.user_timeout}), 32'h0);
        check("rst_rdata", 32'(u_if.user_rdata), 32'h0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("no_strobe_idle", 32'({out_v1, out_slot1}), 32'h0);

        // Bring-up: reset write, volumes, then two polls (not ready, ready).
        exp_q.push_back(cmd_wr(7'h00, 16'h0000)); frame(20'h0, 1'b0, 20'h0);
        exp_q.push_back(cmd_wr(7'h02, 16'h0000)); frame(20'h0, 1'b0, 20'h0);
        exp_q.push_back(cmd_wr(7'h18, 16'h0808)); frame(20'h0, 1'b0, 20'h0);
        exp_q.push_back(cmd_rd(7'h26));           frame(20'h0, 1'b0, 20'h0);
        exp_q.push_back(cmd_none());              frame(20'h7C000, 1'b1, 20'h00070);
        exp_q.push_back(cmd_none());              frame(20'h26000, 1'b1, 20'h00070);
        check("ready_before", 32'(codec_ready), 32'h0);
        exp_q.push_back(cmd_rd(7'h26));           frame(20'h0, 1'b0, 20'h0);
        check("ready_still_low", 32'(codec_ready), 32'h0);
        exp_q.push_back(cmd_none());              frame(20'h26000, 1'b1, 20'h000F0);
        check("ready_rise", 32'(codec_ready), 32'h1);

        // Write 0x18 = 0x1F1F.
        set_req(1'b1, 1'b0, 7'h18, 16'h1F1F);
        exp_q.push_back(cmd_wr(7'h18, 16'h1F1F)); frame(20'h0, 1'b0, 20'h0);
        set_req(1'b0, 1'b0, 7'h00, 16'h0000);
        check("wr_ack", 32'({obs_ack, late_ack}), 32'b10);
        exp_q.push_back(cmd_none());              frame(20'h0, 1'b0, 20'h0);
        check("wr_no_reack", 32'(obs_ack), 32'h0);

        // Read 0x7C; a request during the wait is ignored.
        set_req(1'b1, 1'b1, 7'h7C, 16'h0000);
        exp_q.push_back(cmd_rd(7'h7C));           frame(20'h0, 1'b0, 20'h0);
        check("rd_ack", 32'(obs_ack), 32'h1);
        set_req(1'b1, 1'b0, 7'h05, 16'hAAAA);
        exp_q.push_back(cmd_none());              frame(20'h0, 1'b0, 20'h0);
        check("uwait_no_ack", 32'({obs_ack, obs_rv}), 32'h0);
        set_req(1'b0, 1'b0, 7'h00, 16'h0000);
        exp_q.push_back(cmd_none());              frame(20'h7C000, 1'b1, 20'h41440);
        check("rd_valid", 32'({obs_rv, late_rv, obs_tmo}), 32'b100);
        check("rd_data", 32'(u_if.user_rdata), 32'h4144);

        // Read 0x26 with no response: timeout on the fourth strobe.
        set_req(1'b1, 1'b1, 7'h26, 16'h0000);
        exp_q.push_back(cmd_rd(7'h26));           frame(20'h0, 1'b0, 20'h0);
        set_req(1'b0, 1'b0, 7'h00, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            frame(20'h0, 1'b0, 20'h0);
            check("tmo_early", 32'({obs_tmo, obs_rv}), 32'h0);
        end
        frame(20'h0, 1'b0, 20'h0);
        check("tmo_pulse", 32'({obs_tmo, late_tmo, obs_rv}), 32'b100);
        check("tmo_rdata_kept", 32'(u_if.user_rdata), 32'h4144);

        // Read 0x10: foreign status ignored, match on the timeout strobe wins.
        set_req(1'b1, 1'b1, 7'h10, 16'h0000);
        exp_q.push_back(cmd_rd(7'h10));           frame(20'h0, 1'b0, 20'h0);
        check("rd2_ack", 32'(obs_ack), 32'h1);
        set_req(1'b0, 1'b0, 7'h00, 16'h0000);
        frame(20'h0, 1'b0, 20'h0);
        frame(20'h26000, 1'b1, 20'h55550);
        check("foreign_ignored", 32'({obs_rv, obs_tmo}), 32'h0);
        frame(20'h0, 1'b0, 20'h0);
        frame(20'h10000, 1'b1, 20'hBEEF0);
        check("match_beats_tmo", 32'({obs_rv, obs_tmo}), 32'b10);
        check("rd2_data", 32'(u_if.user_rdata), 32'hBEEF);

        // Next request after the read is accepted.
        set_req(1'b1, 1'b0, 7'h02, 16'h1234);
        exp_q.push_back(cmd_wr(7'h02, 16'h1234)); frame(20'h0, 1'b0, 20'h0);
        check("wr2_ack", 32'(obs_ack), 32'h1);
        set_req(1'b0, 1'b0, 7'h00, 16'h0000);

        // Reset in the middle of a read wait.
        set_req(1'b1, 1'b1, 7'h7C, 16'h0000);
        exp_q.push_back(cmd_rd(7'h7C));           frame(20'h0, 1'b0, 20'h0);
        set_req(1'b0, 1'b0, 7'h00, 16'h0000);
        frame(20'h0, 1'b0, 20'h0);
        #2 rst = 1'b1;
        #1;
        check("midrst_slots", 32'({out_v1, out_v2, out_slot1 | out_slot2}), 32'h0);
        check("midrst_flags", 32'({codec_ready, init_error, u_if.user_ack, u_if.user_rdata_valid,
                                   u_if.user_timeout}), 32'h0);
        check("midrst_rdata", 32'(u_if.user_rdata), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_quiet", 32'({out_v1, out_slot1}), 32'h0);

        // Restart with a codec that never reports ready; requester keeps asking.
        set_req(1'b1, 1'b0, 7'h05, 16'h0001);
        exp_q.push_back(cmd_wr(7'h00, 16'h0000)); frame(20'h0, 1'b0, 20'h0);
        check("restart_no_tmo", 32'({obs_ack, obs_tmo, obs_rv}), 32'h0);
        exp_q.push_back(cmd_wr(7'h02, 16'h0000)); frame(20'h0, 1'b0, 20'h0);
        exp_q.push_back(cmd_wr(7'h18, 16'h0808)); frame(20'h0, 1'b0, 20'h0);

        polls = 0; last_poll = -1; since = 99; max_gap = 0; min_gap = 99;
        acks = 0; err_frame = -1; polls_at_err = 0; ready_seen = 0;
        for (int f = 0; f < 2000; f++) begin
            if (since == 2 && (polls % 2) == 1) frame(20'h26000, 1'b1, 20'h00070);
            else                                frame(20'h0, 1'b0, 20'h0);
            since++;
            if (obs_ack) acks++;
            if (codec_ready) ready_seen = 1;
            if (obs_v1 && obs_s1 == 20'hA6000) begin
                polls++;
                if (last_poll >= 0) begin
                    if (f - last_poll > max_gap) max_gap = f - last_poll;
                    if (f - last_poll < min_gap) min_gap = f - last_poll;
                end
                last_poll = f;
                since = 0;
            end
            if (init_error && err_frame < 0) begin
                err_frame = f;
                polls_at_err = polls;
            end
            if (err_frame >= 0 && f == err_frame + 12) break;
        end
        set_req(1'b0, 1'b0, 7'h00, 16'h0000);
        check("err_reached", 32'(err_frame >= 0), 32'h1);
        check("polls_at_err", 32'(polls_at_err), 32'd255);
        check("poll_max_gap", 32'(max_gap), 32'd5);
        check("poll_min_gap", 32'(min_gap), 32'd4);
        check("polling_continues", 32'(polls > polls_at_err), 32'h1);
        check("err_sticky", 32'(init_error), 32'h1);
        check("never_ready", 32'(ready_seen), 32'h0);
        check("never_acked", 32'(acks), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
